time_display_scan: RTL and testbench

- Reader/display end of the digital clock's time outputs: samples binary sec/min/hr, converts each field to two BCD digits, and drives a 6-digit multiplexed 7-segment display.
- Conversion is sequential (subtract-by-10); the display buffer updates coherently once per scan frame.
- Sits between the clock core and the board display pins.

---
 rtl/time_display_scan.sv | 174 +++++++++++++++++
 tb/tb_time_display_scan.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/time_display_scan.sv
// Samples binary sec/min/hr once per scan frame, converts each field to BCD by repeated
// subtract-by-10 and drives a 6-digit multiplexed 7-segment display. Optional macro: BLINK_DP_EN.
module time_display_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter bit COMMON_ANODE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hr,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       upd
);
    localparam int   CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic INACT = COMMON_ANODE;

    if (SCAN_DIV < 4) begin : g_bad_div
        $error("SCAN_DIV must be at least 4");
    end

    typedef enum logic [2:0] {IDLE, CONV_S, CONV_M, CONV_H, COMMIT} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic             tc, wrap, ge10;
    logic [5:0]       work;
    logic [2:0]       tens;
    logic [5:0]       min_s;
    logic [4:0]       hr_s;
    logic [5:0][3:0]  cdig;
    logic [5:0][3:0]  dbuf;
    logic [3:0]       cur;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    assign tc   = (cnt == CNT_W'(SCAN_DIV - 1));
    assign wrap = tc && (idx == 3'd5);
    assign ge10 = (work >= 6'd10);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (tc) begin
            cnt <= '0;
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (wrap) state_nx = CONV_S;
            CONV_S:  if (!ge10) state_nx = CONV_M;
            CONV_M:  if (!ge10) state_nx = CONV_H;
            CONV_H:  if (!ge10) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // conversion: each CONV state either peels off a ten or stores the digit pair and loads the next field
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            upd   <= 1'b0;
            work  <= '0;
            tens  <= '0;
            min_s <= '0;
            hr_s  <= '0;
            cdig  <= '0;
            dbuf  <= '0;
        end else begin
            state <= state_nx;
            upd   <= (state == COMMIT);
            case (state)
                IDLE: begin
                    if (wrap) begin
                        work  <= sec;
                        min_s <= min;
                        hr_s  <= hr;
                        tens  <= '0;
                    end
                end
                CONV_S, CONV_M, CONV_H: begin
                    if (ge10) begin
                        work <= work - 6'd10;
                        tens <= tens + 3'd1;
                    end else begin
                        tens <= '0;
                        case (state)
                            CONV_S: begin
                                cdig[0] <= work[3:0];
                                cdig[1] <= {1'b0, tens};
                                work    <= min_s;
                            end
                            CONV_M: begin
                                cdig[2] <= work[3:0];
                                cdig[3] <= {1'b0, tens};
                                work    <= {1'b0, hr_s};
                            end
                            default: begin
                                cdig[4] <= work[3:0];
                                cdig[5] <= {1'b0, tens};
                            end
                        endcase
                    end
                end
                COMMIT:  dbuf <= cdig;
                default: ;
            endcase
        end
    end

    always_comb begin
        cur = '0;
        case (idx)
            3'd0:    cur = dbuf[0];
            3'd1:    cur = dbuf[1];
            3'd2:    cur = dbuf[2];
            3'd3:    cur = dbuf[3];
            3'd4:    cur = dbuf[4];
            3'd5:    cur = dbuf[5];
            default: cur = '0;
        endcase
    end

    // display output registers: one cycle behind the digit index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= {6{INACT}};
            seg <= {7{INACT}};
        end else begin
            an  <= (6'b000001 << idx) ^ {6{INACT}};
            seg <= seg_decode(cur) ^ {7{INACT}};
        end
    end

`ifdef BLINK_DP_EN
    logic dp_r;
    // colon separators lit on digits 2 and 4 while the committed seconds are even
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_r <= INACT;
        end else begin
            dp_r <= ((idx == 3'd2 || idx == 3'd4) && !dbuf[0][0]) ? ~INACT : INACT;
        end
    end
    assign dp = dp_r;
`else
    assign dp = INACT;
`endif

endmodule

// File: tb/tb_time_display_scan.sv
// Directed bench for time_display_scan with SCAN_DIV=4, COMMON_ANODE=1.
module tb_time_display_scan;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] sec, min;
    logic [4:0] hr;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       upd;

    int ncmp  = 0;
    int nfail = 0;

    typedef struct {
        logic [5:0]      s;
        logic [5:0]      m;
        logic [4:0]      h;
        int              lat;
        logic [5:0][6:0] sg;
    } vec_t;

    vec_t vecs [5];

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S5 = 7'b0010010, S6 = 7'b0000010,
                           S7 = 7'b1111000, S8 = 7'b0000000, S9 = 7'b0010000;
    localparam logic [5:0] AN5 = 6'b011111, AN0 = 6'b111110;

    time_display_scan #(.SCAN_DIV(4), .COMMON_ANODE(1)) dut (
        .clk(clk), .rst(rst), .sec(sec), .min(min), .hr(hr),
        .seg(seg), .dp(dp), .an(an), .upd(upd)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h,
                                input int lat, input logic [6:0] d0, input logic [6:0] d1,
                                input logic [6:0] d2, input logic [6:0] d3,
                                input logic [6:0] d4, input logic [6:0] d5);
        vec_t v;
        v.s = s; v.m = m; v.h = h; v.lat = lat;
        v.sg[0] = d0; v.sg[1] = d1; v.sg[2] = d2;
        v.sg[3] = d3; v.sg[4] = d4; v.sg[5] = d5;
        return v;
    endfunction

    function automatic logic exp_dp(input int j, input logic even);
`ifdef BLINK_DP_EN
        return ((j == 2 || j == 4) && even) ? 1'b0 : 1'b1;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [5:0] exp_an(input int j);
        logic [5:0] one;
        one = 6'b000001;
        return ~(one << j);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_an(input logic [5:0] v, input bit eq);
        for (int i = 0; i < 64; i++) begin
            if ((an == v) == eq) return;
            step();
        end
        ncmp++;
        nfail++;
        $display("FAIL wait_an: timeout, an=%b target=%b", an, v);
    endtask

    // leaves the bench at the negedge one cycle after a 5->0 wrap edge
    task automatic sync_frame();
        wait_an(AN5, 1'b0);
        wait_an(AN5, 1'b1);
        wait_an(AN0, 1'b1);
    endtask

    task automatic check_first_frame();
        for (int n = 1; n <= 24; n++) begin
            step();
            chk("scan_an", 32'(an), 32'(exp_an((n - 1) / 4)));
            chk("scan_seg", 32'(seg), 32'(S0));
            chk("scan_upd", 32'(upd), 32'(0));
            chk("scan_dp", 32'(dp), 32'(exp_dp((n - 1) / 4, 1'b1)));
        end
    endtask

    task automatic run_vec(input vec_t v);
        sec = v.s; min = v.m; hr = v.h;
        sync_frame();
        for (int k = 1; k <= v.lat + 1; k++) begin
            chk("upd_timing", 32'(upd), 32'(k == v.lat));
            step();
        end
        sync_frame();
        for (int j = 0; j < 6; j++) begin
            chk("disp_an", 32'(an), 32'(exp_an(j)));
            chk("disp_seg", 32'(seg), 32'(v.sg[j]));
            chk("disp_dp", 32'(dp), 32'(exp_dp(j, ~v.s[0])));
            if (j < 5) repeat (4) step();
        end
    endtask

    initial begin
        vecs[0] = mk(6'd36, 6'd5,  5'd12, 8,  S6, S3, S5, S0, S2, S1);
        vecs[1] = mk(6'd37, 6'd5,  5'd12, 8,  S7, S3, S5, S0, S2, S1);
        vecs[2] = mk(6'd59, 6'd59, 5'd23, 16, S9, S5, S9, S5, S3, S2);
        vecs[3] = mk(6'd63, 6'd63, 5'd31, 19, S3, S6, S3, S6, S1, S3);
        vecs[4] = mk(6'd0,  6'd0,  5'd0,  4,  S0, S0, S0, S0, S0, S0);

        rst = 1'b0; sec = 6'd36; min = 6'd5; hr = 5'd12;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_an", 32'(an), 32'(6'b111111));
            chk("rst_seg", 32'(seg), 32'(7'b1111111));
            chk("rst_upd", 32'(upd), 32'(0));
            chk("rst_dp", 32'(dp), 32'(1));
        end
        rst = 1'b1;
        check_first_frame();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // input change after the wrap must not reach the buffer until the next frame
        sec = 6'd37; min = 6'd5; hr = 5'd12;
        sync_frame();
        repeat (2) step();
        sec = 6'd38;
        sync_frame();
        chk("coh_d0_old", 32'(seg), 32'(S7));
        repeat (4) step();
        chk("coh_d1_old", 32'(seg), 32'(S3));
        sync_frame();
        chk("coh_d0_new", 32'(seg), 32'(S8));

        // reset two cycles into minute conversion
        sec = 6'd37; min = 6'd59; hr = 5'd12;
        sync_frame();
        repeat (5) step();
        rst = 1'b0;
        #1;
        chk("async_an", 32'(an), 32'(6'b111111));
        chk("async_seg", 32'(seg), 32'(7'b1111111));
        chk("async_upd", 32'(upd), 32'(0));
        repeat (2) step();
        rst = 1'b1;
        check_first_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
